tile_board_ctrl: RTL

Game-board state machine for the 6x6 tile-matching game. It turns debounced push-button levels into cursor movement, tile selection, pair matching and mismatch blinking. It drives the `hidden_bus`, `blink_bus` and `sel_bus` vectors consumed directly by the VGA timing/render stage. Tile index convention matches the renderer: `k = x*6 + y`, with `x` the column (0..5, left to right) and `y` the row (0..5, top to bottom).

---
 rtl/tile_board_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/tile_board_ctrl.sv
// tile_board_ctrl
// Board state machine for the 6x6 tile-matching game. Button presses move a
// wrapping cursor, pick tiles, remove matching pairs and start a timed blink
// on a mismatching pair. Tile index k = x*6 + y (x = column, y = row).
//
// Ports
//   clk100_in   in   1   system clock
//   rst_n_in    in   1   asynchronous active-low reset
//   btn_in      in   5   debounced button levels {select, right, left, down, up}
//   hidden_bus  out  36  bit k set: tile k removed
//   blink_bus   out  36  bit k set: tile k in mismatch blink
//   sel_bus     out  36  bit k set: selection border on tile k
//   pairs_left  out  5   unmatched pairs remaining
//   cleared     out  1   board empty
module tile_board_ctrl #(
  parameter int             BLINK_CYCLES = 100_000_000,
  parameter logic [179:0]   LAYOUT = {2{5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12,
                                         5'd11, 5'd10, 5'd9,  5'd8,  5'd7,  5'd6,
                                         5'd5,  5'd4,  5'd3,  5'd2,  5'd1,  5'd0}}
) (
  input  logic        clk100_in,
  input  logic        rst_n_in,
  input  logic [4:0]  btn_in,
  output logic [35:0] hidden_bus,
  output logic [35:0] blink_bus,
  output logic [35:0] sel_bus,
  output logic [4:0]  pairs_left,
  output logic        cleared
);

  localparam int TW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_BLINK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [4:0]    r_btn_q;
  logic [1:0]    r_state;
  logic [2:0]    r_cx;
  logic [2:0]    r_cy;
  logic [5:0]    r_pick;
  logic [35:0]   r_hidden;
  logic [35:0]   r_blink;
  logic [35:0]   r_sel;
  logic [4:0]    r_pairs;
  logic          r_cleared;
  logic [TW-1:0] r_timer;

  logic [1:0]    w_state_next;
  logic [2:0]    w_cx_next;
  logic [2:0]    w_cy_next;
  logic [5:0]    w_pick_next;
  logic [35:0]   w_hidden_next;
  logic [35:0]   w_blink_next;
  logic [35:0]   w_sel_next;
  logic [4:0]    w_pairs_next;
  logic [TW-1:0] w_timer_next;

  logic [4:0]    w_press;
  logic          w_up;
  logic          w_down;
  logic          w_left;
  logic          w_right;
  logic          w_select;
  logic [5:0]    w_cur;
  logic [5:0]    w_cur_next;
  logic [35:0]   w_cur_oh;
  logic [35:0]   w_pick_oh;

  function automatic logic [4:0] tile_type(input logic [5:0] k);
    return LAYOUT[int'(k)*5 +: 5];
  endfunction

  // Rising edges only; a held button acts once.
  assign w_press = btn_in & ~r_btn_q;

  // Fixed priority: up > down > left > right > select; lower presses are dropped.
  assign w_up     = w_press[0];
  assign w_down   = w_press[1] & ~w_press[0];
  assign w_left   = w_press[2] & ~|w_press[1:0];
  assign w_right  = w_press[3] & ~|w_press[2:0];
  assign w_select = w_press[4] & ~|w_press[3:0];

  assign w_cur     = {3'b000, r_cx} * 6'd6 + {3'b000, r_cy};
  assign w_cur_oh  = 36'd1 << w_cur;
  assign w_pick_oh = 36'd1 << r_pick;

  always_comb begin
    w_state_next  = r_state;
    w_cx_next     = r_cx;
    w_cy_next     = r_cy;
    w_pick_next   = r_pick;
    w_hidden_next = r_hidden;
    w_blink_next  = r_blink;
    w_pairs_next  = r_pairs;
    w_timer_next  = r_timer;

    case (r_state)
      S_IDLE, S_ONE: begin
        if (w_up) begin
          w_cy_next = (r_cy == 3'd0) ? 3'd5 : r_cy - 3'd1;
        end else if (w_down) begin
          w_cy_next = (r_cy == 3'd5) ? 3'd0 : r_cy + 3'd1;
        end else if (w_left) begin
          w_cx_next = (r_cx == 3'd0) ? 3'd5 : r_cx - 3'd1;
        end else if (w_right) begin
          w_cx_next = (r_cx == 3'd5) ? 3'd0 : r_cx + 3'd1;
        end else if (w_select) begin
          if (r_state == S_IDLE) begin
            if (!r_hidden[w_cur]) begin
              w_pick_next  = w_cur;
              w_state_next = S_ONE;
            end
          end else if (w_cur == r_pick) begin
            w_state_next = S_IDLE;
          end else if (!r_hidden[w_cur]) begin
            if (tile_type(w_cur) == tile_type(r_pick)) begin
              w_hidden_next = r_hidden | w_cur_oh | w_pick_oh;
              w_pairs_next  = r_pairs - 5'd1;
              w_state_next  = (r_pairs == 5'd1) ? S_DONE : S_IDLE;
            end else begin
              w_blink_next = r_blink | w_cur_oh | w_pick_oh;
              w_timer_next = TW'(BLINK_CYCLES - 1);
              w_state_next = S_BLINK;
            end
          end
        end
      end
      S_BLINK: begin
        // Timer is loaded with N-1 so the blink lasts exactly N edges.
        if (r_timer == '0) begin
          w_blink_next = '0;
          w_state_next = S_IDLE;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      S_DONE: begin
        if (w_select) begin
          w_hidden_next = '0;
          w_pairs_next  = 5'd18;
          w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Selection border is computed from next-state values so it lands on the
  // same edge as the action that changes it.
  assign w_cur_next = {3'b000, w_cx_next} * 6'd6 + {3'b000, w_cy_next};

  always_comb begin
    w_sel_next = '0;
    if (w_state_next != S_DONE) begin
      w_sel_next = 36'd1 << w_cur_next;
      if (w_state_next == S_ONE) begin
        w_sel_next = w_sel_next | (36'd1 << w_pick_next);
      end
    end
  end

  always_ff @(posedge clk100_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_btn_q   <= '0;
      r_state   <= S_IDLE;
      r_cx      <= '0;
      r_cy      <= '0;
      r_pick    <= '0;
      r_hidden  <= '0;
      r_blink   <= '0;
      r_sel     <= 36'h1;
      r_pairs   <= 5'd18;
      r_cleared <= 1'b0;
      r_timer   <= '0;
    end else begin
      r_btn_q   <= btn_in;
      r_state   <= w_state_next;
      r_cx      <= w_cx_next;
      r_cy      <= w_cy_next;
      r_pick    <= w_pick_next;
      r_hidden  <= w_hidden_next;
      r_blink   <= w_blink_next;
      r_sel     <= w_sel_next;
      r_pairs   <= w_pairs_next;
      r_cleared <= (w_state_next == S_DONE);
      r_timer   <= w_timer_next;
    end
  end

  assign hidden_bus = r_hidden;
  assign blink_bus  = r_blink;
  assign sel_bus    = r_sel;
  assign pairs_left = r_pairs;
  assign cleared    = r_cleared;

endmodule
